accum_sequencer: RTL and testbench

ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

---
 rtl/accum_sequencer.sv | 140 ++++++++++++++
 tb/tb_accum_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_sequencer.sv
// accum_sequencer: accepts a job of `len` unsigned operands over a
// valid/ready stream, sums them modulo 2^N with a sticky overflow flag,
// and presents the result on a valid/ready output until it is taken.
module accum_sequencer #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [N-1:0]     SUM_ZERO = {N{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [N-1:0]     acc_r;
    logic [N-1:0]     acc_nxt_s;
    logic             sticky_r;
    logic             sticky_nxt_s;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] rem_nxt_s;
    logic [N-1:0]     out_sum_r;
    logic [N-1:0]     out_sum_nxt_s;
    logic             out_carry_r;
    logic             out_carry_nxt_s;
    logic [N:0]       sum_s;

    // Adder with carry-in tied low; bit N is the carry out of bit N-1.
    assign sum_s = {1'b0, acc_r} + {1'b0, in_data};

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        sticky_nxt_s    = sticky_r;
        rem_nxt_s       = rem_r;
        out_sum_nxt_s   = out_sum_r;
        out_carry_nxt_s = out_carry_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_nxt_s    = SUM_ZERO;
                    sticky_nxt_s = 1'b0;
                    if (len != CNT_ZERO) begin
                        rem_nxt_s   = len;
                        state_nxt_s = ACCUM;
                    end else begin
                        // Empty job: the result is known now, publish it.
                        rem_nxt_s       = CNT_ZERO;
                        out_sum_nxt_s   = SUM_ZERO;
                        out_carry_nxt_s = 1'b0;
                        state_nxt_s     = HOLD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_nxt_s    = sum_s[N-1:0];
                    sticky_nxt_s = sticky_r | sum_s[N];
                    rem_nxt_s    = rem_r - CNT_ONE;
                    if (rem_r == CNT_ONE) begin
                        // Last beat: result registers load together with acc
                        // so out_valid rises with no bubble.
                        out_sum_nxt_s   = sum_s[N-1:0];
                        out_carry_nxt_s = sticky_r | sum_s[N];
                        state_nxt_s     = HOLD;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register; reset wins over every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Accumulator, sticky carry, beat counter and published result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= SUM_ZERO;
            sticky_r    <= 1'b0;
            rem_r       <= CNT_ZERO;
            out_sum_r   <= SUM_ZERO;
            out_carry_r <= 1'b0;
        end else begin
            acc_r       <= acc_nxt_s;
            sticky_r    <= sticky_nxt_s;
            rem_r       <= rem_nxt_s;
            out_sum_r   <= out_sum_nxt_s;
            out_carry_r <= out_carry_nxt_s;
        end
    end

    // Handshake flags decode from the state register alone.
    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == HOLD);
    assign busy      = (state_r != IDLE);
    assign out_sum   = out_sum_r;
    assign out_carry = out_carry_r;

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer with N=4, CNT_W=8.
module tb_accum_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_carry;
    logic       busy;

    int errors;
    int checks;

    // obs layout: {out_valid, in_ready, busy, out_carry, out_sum}
    logic [7:0] obs;
    logic [7:0] exp_v;

    accum_sequencer #(.N(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; len = 8'd3; in_valid = 1'b1; in_data = 4'd9; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        obs = {out_valid, in_ready, busy, out_carry, out_sum};
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs, 8'h00);
        end
    endtask

    task automatic test_basic();
        start = 1'b1; len = 8'd3; tick(); start = 1'b0;
        obs = {out_valid, in_ready, busy, out_carry, out_sum};
        checks++;
        if (obs[7:5] !== 3'b011) begin
            errors++; $display("FAIL basic_accum_flags: got %b expected %b", obs[7:5], 3'b011);
        end
        in_valid = 1'b1; in_data = 4'd3; tick();
        in_data = 4'd4; tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b expected %b", out_valid, 1'b0);
        end
        in_data = 4'd5; tick(); in_valid = 1'b0;
        obs = {out_valid, in_ready, busy, out_carry, out_sum};
        exp_v = {3'b101, 1'b0, 4'd12};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL basic_result: got %h expected %h", obs, exp_v);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        obs = {out_valid, in_ready, busy, out_carry, out_sum};
        exp_v = {3'b000, 1'b0, 4'd12};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL basic_idle_keeps_sum: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_overflow();
        start = 1'b1; len = 8'd3; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 4'd15; tick();
        in_data = 4'd1; tick();
        checks++;
        if ({out_carry, out_sum} !== {1'b0, 4'd12}) begin
            errors++; $display("FAIL ovf_accum_keeps_prev: got %h expected %h", {out_carry, out_sum}, {1'b0, 4'd12});
        end
        in_data = 4'd1; tick(); in_valid = 1'b0;
        obs = {out_valid, in_ready, busy, out_carry, out_sum};
        exp_v = {3'b101, 1'b1, 4'd1};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL ovf_sticky_result: got %h expected %h", obs, exp_v);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_empty_job();
        start = 1'b1; len = 8'd0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL empty_ready_idle: got %b expected %b", in_ready, 1'b0);
        end
        tick(); start = 1'b0;
        obs = {out_valid, in_ready, busy, out_carry, out_sum};
        exp_v = {3'b101, 1'b0, 4'd0};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL empty_result: got %h expected %h", obs, exp_v);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b00) begin
            errors++; $display("FAIL empty_return_idle: got %b expected %b", {busy, in_ready}, 2'b00);
        end
    endtask

    task automatic test_backpressure();
        start = 1'b1; len = 8'd2; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 4'd6; tick(); in_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            start = 1'b1; len = 8'd5; in_data = 4'd9;
            tick();
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b011) begin
                errors++; $display("FAIL bp_gap_%0d: got %b expected %b", g, {out_valid, in_ready, busy}, 3'b011);
            end
        end
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'd7; tick(); in_valid = 1'b0;
        for (int h = 0; h < 5; h++) begin
            start = (h % 2 == 0) ? 1'b1 : 1'b0;
            obs = {out_valid, in_ready, busy, out_carry, out_sum};
            exp_v = {3'b101, 1'b0, 4'd13};
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL bp_hold_%0d: got %h expected %h", h, obs, exp_v);
            end
            tick();
        end
        start = 1'b1; out_ready = 1'b1; tick();
        start = 1'b0; out_ready = 1'b0;
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL bp_idle_after_ready: got %b expected %b", {out_valid, busy}, 2'b00);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_start_at_handshake: got %b expected %b", busy, 1'b0);
        end
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1; len = 8'd3; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 4'd5; tick();
        rst = 1'b1; start = 1'b1; out_ready = 1'b1; tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        obs = {out_valid, in_ready, busy, out_carry, out_sum};
        checks++;
        if (obs !== 8'h00) begin
            errors++; $display("FAIL rst_mid_outputs: got %h expected %h", obs, 8'h00);
        end
        start = 1'b1; len = 8'd2; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 4'd2; tick();
        in_data = 4'd2; tick(); in_valid = 1'b0;
        obs = {out_valid, in_ready, busy, out_carry, out_sum};
        exp_v = {3'b101, 1'b0, 4'd4};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL rst_new_job: got %h expected %h", obs, exp_v);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_exhaustive_pairs();
        logic [5:0] exp_p;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start = 1'b1; len = 8'd2; tick(); start = 1'b0;
                in_valid = 1'b1; in_data = 4'(a); tick();
                in_data = 4'(b); tick(); in_valid = 1'b0;
                exp_p = {1'b1, 5'(a + b)};
                checks++;
                if ({out_valid, out_carry, out_sum} !== exp_p) begin
                    errors++; $display("FAIL pair_%0d_%0d: got %h expected %h", a, b, {out_valid, out_carry, out_sum}, exp_p);
                end
                out_ready = 1'b1; tick(); out_ready = 1'b0;
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_empty_job();
        test_backpressure();
        test_reset_mid_job();
        test_exhaustive_pairs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
